// File: rtl/wb_pkg.sv
// Shared types and constants for the register-bank writeback queue.
package wb_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Register 0 is hardwired and addresses past the bank are never written.
    function automatic logic isWritable(input logic [ADDR_W-1:0] dest);
        return (dest != '0) && (32'(dest) < NUM_REGS);
    endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Result handshakes, register-bank write port and decode hazard lookup.
interface writeback_queue_if #(
    parameter int unsigned DEPTH = 4
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                        aluValid;
    logic                        aluReady;
    logic [wb_pkg::ADDR_W-1:0]   aluDest;
    logic [wb_pkg::DATA_W-1:0]   aluData;
    logic                        memValid;
    logic                        memReady;
    logic [wb_pkg::ADDR_W-1:0]   memDest;
    logic [wb_pkg::DATA_W-1:0]   memData;
    logic                        regWrite;
    logic [wb_pkg::ADDR_W-1:0]   regD;
    logic [wb_pkg::DATA_W-1:0]   writeData;
    logic [wb_pkg::ADDR_W-1:0]   regS;
    logic [wb_pkg::ADDR_W-1:0]   regT;
    logic                        hazardS;
    logic                        hazardT;
    logic [CNT_W-1:0]            qCount;

    // The queue is the write-side master of the bank.
    modport master (
        input  aluValid, aluDest, aluData, memValid, memDest, memData, regS, regT,
        output aluReady, memReady, regWrite, regD, writeData, hazardS, hazardT, qCount
    );

    modport slave (
        output aluValid, aluDest, aluData, memValid, memDest, memData, regS, regT,
        input  aluReady, memReady, regWrite, regD, writeData, hazardS, hazardT, qCount
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order result queue; exposes per-entry occupancy and dest for hazard lookup.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_push,
    input  wb_entry_t                     i_entry,
    input  logic                          i_pop,
    output wb_entry_t                     o_head,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic [DEPTH-1:0]              o_valid,
    output logic [ADDR_W-1:0]             o_dest [DEPTH]
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointers wrap naturally; the count alone separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_entry;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_comb begin
        logic [PTR_W-1:0] w_off;
        w_off = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_off      = PTR_W'(i) - r_rd_ptr;
            o_dest[i]  = r_mem[i].dest;
            o_valid[i] = ({1'b0, w_off} < r_count);
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: arbitrates ALU/load results, drains them to the bank, flags RAW hazards.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    writeback_queue_if.master bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              w_space;
    logic              w_alu_xfer;
    logic              w_mem_xfer;
    logic              w_push;
    logic              w_pop;
    wb_entry_t         w_push_entry;
    wb_entry_t         w_head;
    logic [CNT_W-1:0]  w_count;
    logic [DEPTH-1:0]  w_valid;
    logic [ADDR_W-1:0] w_dest [DEPTH];
    logic              w_haz_s;
    logic              w_haz_t;

    logic              r_rr_last;  // 0: ALU granted last, 1: load granted last
    logic              r_reg_write;
    logic [ADDR_W-1:0] r_reg_d;
    logic [DATA_W-1:0] r_write_data;

    // No pass-through when full; ready never depends on the source's own valid.
    assign w_space      = (w_count < CNT_W'(DEPTH));
    assign bus.aluReady = rst_n & w_space & (~bus.memValid | r_rr_last);
    assign bus.memReady = rst_n & w_space & (~bus.aluValid | ~r_rr_last);
    assign w_alu_xfer   = bus.aluValid & bus.aluReady;
    assign w_mem_xfer   = bus.memValid & bus.memReady;
    assign w_pop        = (w_count != '0);

    always_comb begin
        w_push_entry = '{dest: bus.aluDest, data: bus.aluData};
        w_push       = 1'b0;
        if (w_alu_xfer) begin
            w_push = isWritable(bus.aluDest);
        end else if (w_mem_xfer) begin
            w_push_entry = '{dest: bus.memDest, data: bus.memData};
            w_push       = isWritable(bus.memDest);
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_valid (w_valid),
        .o_dest  (w_dest)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_reg_d      <= '0;
            r_write_data <= '0;
        end else begin
            if (w_alu_xfer)      r_rr_last <= 1'b0;
            else if (w_mem_xfer) r_rr_last <= 1'b1;
            r_reg_write <= w_pop;
            if (w_pop) begin
                r_reg_d      <= w_head.dest;
                r_write_data <= w_head.data;
            end
        end
    end

    always_comb begin
        w_haz_s = r_reg_write && (r_reg_d == bus.regS);
        w_haz_t = r_reg_write && (r_reg_d == bus.regT);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (w_valid[i] && (w_dest[i] == bus.regS)) w_haz_s = 1'b1;
            if (w_valid[i] && (w_dest[i] == bus.regT)) w_haz_t = 1'b1;
        end
    end

    assign bus.hazardS   = (bus.regS != '0) & w_haz_s;
    assign bus.hazardT   = (bus.regT != '0) & w_haz_t;
    assign bus.regWrite  = r_reg_write;
    assign bus.regD      = r_reg_d;
    assign bus.writeData = r_write_data;
    assign bus.qCount    = w_count;

endmodule
